sync_fifo_case: RTL and testbench
=================================

# sync_fifo_case

Single-clock synchronous FIFO buffering WIDTH-bit words between a producer and a consumer in the same clock domain. Write and read enables are decoded together as a 2-bit `{we,re}` command each cycle. Full (`f`) and empty (`e`) flags gate the producer and consumer. Output data is registered and holds its value between reads.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 8, number of storage words; power of two, ≥2; address width = $clog2(DEPTH), occupancy counter width = $clog2(DEPTH)+1

- `clk`  input  1  single clock; all state changes on rising edge
- `rst`  input  1  asynchronous, active-low reset (0 = reset)
- `we`  input  1  write request
- `re`  input  1  read request
- `din`  input  WIDTH  write data, sampled on rising edge when a write is accepted
- `dout`  output  WIDTH  registered read data
- `f`  output  1  full flag, high when occupancy == DEPTH
- `e`  output  1  empty flag, high when occupancy == 0

## Operation
- State: memory array DEPTH×WIDTH (not reset), write pointer, read pointer, occupancy count 0..DEPTH, `dout` register.
- Reset (rst=0, asynchronous, no clock needed): pointers=0, count=0, `dout`=0, so `e`=1 and `f`=0. Reset mid-operation discards all stored data.
- Each edge, decode `{we,re}` using flag values from before the edge:
  - 00: hold all state.
  - 10: if not full: mem[wptr]<=din, wptr+1, count+1. If full: write dropped, no state change.
  - 01: if not empty: dout<=mem[rptr], rptr+1, count−1. If empty: read ignored, `dout` holds.
  - 11: read done if not empty, write done if not full, independently.
    - Mid-level: both done, count unchanged.
    - Empty: write only, count+1, `dout` holds.
    - Full: read only, count−1, `din` dropped.
- Pointers wrap from DEPTH−1 to 0 (modulo DEPTH). Order is strictly first-in first-out across wrap.
- `f` and `e` are decoded combinationally from the registered count. They are never both high.
- `dout` changes only on an accepted read or on reset.

## Timing
- Write: `din` is captured at the accepting edge. The word is readable from the next cycle.
- Read latency: 1 cycle. `dout` is valid after the edge that accepts the read.
- Flags update after the same edge that changes the count, with no further delay.
- No combinational path from `we`/`re`/`din` to any output.

## Configuration
- `SYNCH_FIFO_ASSERT_EN` defined: include simulation-only concurrent assertions, disabled while rst=0. Each failure reports `$error` with the failing condition.
  - count ≤ DEPTH.
  - !(f && e).
  - Count tracks accepted writes minus accepted reads.
  - An accepted read while `e`=0 updates `dout` on that edge.
  - A write with `f`=1 leaves count unchanged.
- Not defined: no assertion code is compiled. Functional behaviour is identical either way.

## Test plan
- Reset: drive rst=0 between clock edges with count=5 → immediately e=1, f=0, dout=0. After release, first write lands at address 0.
- Fill/overflow (DEPTH=8, period 100): 9 consecutive writes of din=1..9 → f=1 after the 8th edge. Word 9 is dropped and count stays 8.
- Drain/underflow: 9 reads from the full state → dout=1,2,…,8 on successive edges, e=1 after the 8th. The 9th read leaves dout=8.
- Simultaneous at boundaries:
  - we=re=1 while empty with din=0x55 → e=0, count=1, dout unchanged.
  - we=re=1 while full → count=7, dout=oldest word, din dropped.
- Simultaneous mid-level: count=3, we=re=1 for 4 cycles → count stays 3, dout returns the stored words in order, then the first newly written word.
- Wrap-around: write 6, read 6, write 6, read 6 → both pointers wrap and all 12 words are returned in write order with no loss.

Source files
------------

// File: rtl/sync_fifo_case.sv
// Single-clock FIFO with registered read data and {we,re} case-decoded commands.
// Define SYNCH_FIFO_ASSERT_EN to compile the simulation-only concurrent assertions.
module sync_fifo_case #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             f,
  output logic             e
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             wr_ok, rd_ok;

  assign f = (count == CW'(DEPTH));
  assign e = (count == '0);

  // Each half of a simultaneous command is gated by its own flag only.
  always_comb begin
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    case ({we, re})
      2'b10:   wr_ok = ~f;
      2'b01:   rd_ok = ~e;
      2'b11: begin
        wr_ok = ~f;
        rd_ok = ~e;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef SYNCH_FIFO_ASSERT_EN
  logic [WIDTH-1:0] head;
  assign head = mem[rptr];

  a_cnt_max: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH))
    else $error("count <= DEPTH violated: count=%0d", count);
  a_not_fe: assert property (@(posedge clk) disable iff (!rst) !(f && e))
    else $error("!(f && e) violated");
  a_cnt_trk: assert property (@(posedge clk) disable iff (!rst)
      1'b1 |=> count == $past(count) + CW'($past(wr_ok)) - CW'($past(rd_ok)))
    else $error("count != past(count) + writes - reads");
  a_rd_dout: assert property (@(posedge clk) disable iff (!rst)
      (re && !e) |=> dout == $past(head))
    else $error("accepted read did not update dout");
  a_wr_full: assert property (@(posedge clk) disable iff (!rst)
      (we && !re && f) |=> count == $past(count))
    else $error("write while full changed count");
`endif
endmodule

// File: tb/tb_sync_fifo_case.sv
// Directed bench for sync_fifo_case: reset, fill/drain limits, simultaneous ops, wrap.
module tb_sync_fifo_case;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       f, e;
  int         n_chk  = 0;
  int         n_pass = 0;

  sync_fifo_case #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .din(din),
    .dout(dout), .f(f), .e(e)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // One clock with the given command; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    we = w; re = r; din = d;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    cyc(1'b0, 1'b1, 8'h00);
    chk(tag, {24'h0, dout}, {24'h0, exp});
  endtask

  initial begin
    // power-on reset, asserted between edges
    #20 rst = 1'b0;
    #5;
    chk("rst_e", e, 1'b1);
    chk("rst_f", f, 1'b0);
    chk("rst_dout", dout, 8'h00);
    #20 rst = 1'b1;

    // fill with 1..9; word 9 is dropped
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 1) chk("fill_e1", e, 1'b0);
      if (i == 7) chk("fill_f7", f, 1'b0);
      if (i >= 8) chk($sformatf("fill_f%0d", i), f, 1'b1);
    end

    // drain 9; dout holds 8 on the ignored read
    for (int i = 1; i <= 9; i++) begin
      rd($sformatf("drain%0d", i), 8'(i > 8 ? 8 : i));
      if (i == 1) chk("drain_f1", f, 1'b0);
      if (i == 7) chk("drain_e7", e, 1'b0);
      if (i >= 8) chk($sformatf("drain_e%0d", i), e, 1'b1);
    end

    // simultaneous while empty: write only, dout holds
    cyc(1'b1, 1'b1, 8'h55);
    chk("se_e", e, 1'b0);
    chk("se_dout", dout, 8'h08);
    rd("se_rd", 8'h55);
    chk("se_e2", e, 1'b1);

    // simultaneous while full: read only, din dropped
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
    chk("sf_full", f, 1'b1);
    cyc(1'b1, 1'b1, 8'hAA);
    chk("sf_f", f, 1'b0);
    chk("sf_dout", dout, 8'h10);
    for (int i = 1; i < 8; i++) rd($sformatf("sf_rd%0d", i), 8'h10 + 8'(i));
    chk("sf_e", e, 1'b1);

    // simultaneous mid-level: count stays 3
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 8'h30 + 8'(k));
      chk($sformatf("mid_dout%0d", k), dout, k < 3 ? 8'h21 + 8'(k) : 8'h30);
      chk($sformatf("mid_ef%0d", k), {e, f}, 2'b00);
    end
    rd("mid_rd1", 8'h31);
    rd("mid_rd2", 8'h32);
    chk("mid_e2", e, 1'b0);
    rd("mid_rd3", 8'h33);
    chk("mid_e3", e, 1'b1);

    // wrap: pointers pass DEPTH-1 -> 0
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 6; i++) rd($sformatf("wr_a%0d", i), 8'h40 + 8'(i));
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h50 + 8'(i));
    for (int i = 0; i < 6; i++) rd($sformatf("wr_b%0d", i), 8'h50 + 8'(i));
    chk("wr_e", e, 1'b1);

    // reset mid-operation with 5 words stored
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i));
    #20 rst = 1'b0;
    #5;
    chk("mrst_e", e, 1'b1);
    chk("mrst_f", f, 1'b0);
    chk("mrst_dout", dout, 8'h00);
    #20 rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h77);
    rd("mrst_rd", 8'h77);
    chk("mrst_e2", e, 1'b1);
    rd("mrst_hold", 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
